bp_cfg_tile_sequencer: RTL and testbench

BP_CFG_TILE_SEQUENCER -- requirements
Module: bp_cfg_tile_sequencer

---
 rtl/bp_cfg_tile_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_bp_cfg_tile_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_tile_sequencer.sv
// bp_cfg_tile_sequencer
//
// Walks every tile of a cc_x_dim_p x cc_y_dim_p core complex over a simple
// valid/ready config bus. The sequence has three passes:
//   1. For each tile: write FREEZE (addr 0x0001, data 1).
//   2. For the same tile: write COREID (addr 0x0002, data y*cc_x_dim_p+x).
//   3. For every tile: write UNFREEZE (addr 0x0001, data 0).
// Tiles are visited x fastest. After the last write, done_o pulses for one
// cycle and the block returns to IDLE.
//
// Optional feature, selected by the macro BP_CFG_SEQ_TIMEOUT_EN:
//   A stall counter watches for timeout_cycles_p consecutive cycles with
//   cfg_v_o=1 and cfg_ready_i=0. When that limit is reached, the block parks
//   in ERROR with timeout_o=1. A new start_i clears the error and restarts
//   the sequence. Without the macro, stalls wait forever and timeout_o is 0.
//
// Ports
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   start_i      begin a sequence (sampled in IDLE and ERROR only)
//   busy_o       sequence in progress (FREEZE/COREID/UNFREEZE/DONE)
//   done_o       one-cycle completion pulse
//   timeout_o    sticky stall error
//   cfg_v_o      config write valid (registered-state function)
//   cfg_ready_i  config bus ready
//   cfg_x_o      target tile column
//   cfg_y_o      target tile row
//   cfg_addr_o   register address
//   cfg_data_o   write data
module bp_cfg_tile_sequencer #(
  parameter int cc_x_dim_p       = 2,
  parameter int cc_y_dim_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int timeout_cycles_p = 255
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  input  logic                                                   start_i,
  output logic                                                   busy_o,
  output logic                                                   done_o,
  output logic                                                   timeout_o,
  output logic                                                   cfg_v_o,
  input  logic                                                   cfg_ready_i,
  output logic [((cc_x_dim_p > 1) ? $clog2(cc_x_dim_p) : 1)-1:0] cfg_x_o,
  output logic [((cc_y_dim_p > 1) ? $clog2(cc_y_dim_p) : 1)-1:0] cfg_y_o,
  output logic [cfg_addr_width_p-1:0]                            cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                            cfg_data_o
);

  localparam int XW = (cc_x_dim_p > 1) ? $clog2(cc_x_dim_p) : 1;
  localparam int YW = (cc_y_dim_p > 1) ? $clog2(cc_y_dim_p) : 1;

  localparam logic [XW-1:0] XMAX = XW'(cc_x_dim_p - 1);
  localparam logic [YW-1:0] YMAX = YW'(cc_y_dim_p - 1);

  localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE = cfg_addr_width_p'(16'h0001);
  localparam logic [cfg_addr_width_p-1:0] ADDR_COREID = cfg_addr_width_p'(16'h0002);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_COREID,
    S_UNFREEZE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;

  logic            xfer;
  logic            last_tile;
  logic [XW-1:0]   next_x;
  logic [YW-1:0]   next_y;
  logic [31:0]     core_id;

`ifdef BP_CFG_SEQ_TIMEOUT_EN
  localparam int SW = $clog2(timeout_cycles_p + 1);
  // The limit is hit on the cycle whose stall would bring the count to
  // timeout_cycles_p, so ERROR begins right after that many stall cycles.
  localparam logic [SW-1:0] STALL_LAST = SW'(timeout_cycles_p - 1);

  logic [SW-1:0]   stall_q, stall_d;
`endif

  // ---- state register ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Tile walk helpers: x is the fast coordinate.
  assign last_tile = (x_q == XMAX) && (y_q == YMAX);
  assign next_x    = (x_q == XMAX) ? '0 : x_q + XW'(1);
  assign next_y    = (x_q == XMAX) ? y_q + YW'(1) : y_q;
  assign xfer      = cfg_v_o && cfg_ready_i;

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
    stall_d = stall_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FREEZE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_FREEZE: begin
        if (xfer) state_d = S_COREID;
      end
      S_COREID: begin
        if (xfer) begin
          if (last_tile) begin
            state_d = S_UNFREEZE;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = S_FREEZE;
            x_d     = next_x;
            y_d     = next_y;
          end
        end
      end
      S_UNFREEZE: begin
        if (xfer) begin
          if (last_tile) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
          end else begin
            x_d     = next_x;
            y_d     = next_y;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (start_i) begin
          state_d = S_FREEZE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    // The timeout overrides the normal hold in a write state.
    if (cfg_v_o) begin
      if (xfer) begin
        stall_d = '0;
      end else if (stall_q == STALL_LAST) begin
        state_d = S_ERROR;
        stall_d = '0;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end else begin
      stall_d = '0;
    end
`endif
  end

  assign core_id = (32'(y_q) * 32'(cc_x_dim_p)) + 32'(x_q);

  // ---- output logic ----
  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    timeout_o  = 1'b0;
    cfg_v_o    = 1'b0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    cfg_x_o    = (cc_x_dim_p > 1) ? x_q : '0;
    cfg_y_o    = (cc_y_dim_p > 1) ? y_q : '0;

    case (state_q)
      S_FREEZE: begin
        busy_o     = 1'b1;
        cfg_v_o    = 1'b1;
        cfg_addr_o = ADDR_FREEZE;
        cfg_data_o = cfg_data_width_p'(1);
      end
      S_COREID: begin
        busy_o     = 1'b1;
        cfg_v_o    = 1'b1;
        cfg_addr_o = ADDR_COREID;
        cfg_data_o = cfg_data_width_p'(core_id);
      end
      S_UNFREEZE: begin
        busy_o     = 1'b1;
        cfg_v_o    = 1'b1;
        cfg_addr_o = ADDR_FREEZE;
        cfg_data_o = '0;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      S_ERROR: begin
`ifdef BP_CFG_SEQ_TIMEOUT_EN
        timeout_o = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bp_cfg_tile_sequencer.sv
// Self-checking bench for bp_cfg_tile_sequencer (3x2 core complex).
// Build with +define+BP_CFG_SEQ_TIMEOUT_EN to exercise the stall timeout.
module tb_bp_cfg_tile_sequencer;

  localparam int X  = 3;
  localparam int Y  = 2;
  localparam int N  = X * Y;
  localparam int TO = 6;
  localparam int XW = (X > 1) ? $clog2(X) : 1;
  localparam int YW = (Y > 1) ? $clog2(Y) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic          busy, done, tmo, v;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [15:0]   addr;
  logic [31:0]   data;

  int checks = 0;
  int errors = 0;
  int rmode  = 3;  // 0 random, 1 always ready, 2 toggle, 3 never ready

  typedef struct {
    bit is_done;
    int x;
    int y;
    int addr;
    int data;
  } beat_t;

  beat_t q[$];

  bp_cfg_tile_sequencer #(
    .cc_x_dim_p      (X),
    .cc_y_dim_p      (Y),
    .cfg_addr_width_p(16),
    .cfg_data_width_p(32),
    .timeout_cycles_p(TO)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .timeout_o  (tmo),
    .cfg_v_o    (v),
    .cfg_ready_i(ready),
    .cfg_x_o    (cx),
    .cfg_y_o    (cy),
    .cfg_addr_o (addr),
    .cfg_data_o (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the full write list of one sequence, derived from the tile
  // count alone, followed by a marker for the done pulse.
  task automatic push_seq();
    beat_t b;
    for (int t = 0; t < N; t++) begin
      b.is_done = 1'b0; b.x = t % X; b.y = t / X;
      b.addr = 1; b.data = 1; q.push_back(b);
      b.addr = 2; b.data = t; q.push_back(b);
    end
    for (int t = 0; t < N; t++) begin
      b.is_done = 1'b0; b.x = t % X; b.y = t / X;
      b.addr = 1; b.data = 0; q.push_back(b);
    end
    b.is_done = 1'b1; b.x = 0; b.y = 0; b.addr = 0; b.data = 0;
    q.push_back(b);
  endtask

  // Ready driver.
  initial begin
    int run0;
    run0  = 0;
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: begin
          if (run0 >= 4) ready = 1'b1;
          else ready = ($urandom_range(0, 1) == 1);
          run0 = ready ? 0 : run0 + 1;
        end
        1: ready = 1'b1;
        2: ready = ~ready;
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  logic          pv = 1'b0, pxf = 1'b0;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [15:0]   pa;
  logic [31:0]   pd;

  always @(negedge clk) begin
    if (rst) begin
      pv  <= 1'b0;
      pxf <= 1'b0;
    end else begin
      if (pv && !pxf && v)
        chk("hold_stable", {cx, cy, addr, data}, {px, py, pa, pd});
      if (v && ready) begin
        chk("busy_in_xfer", busy, 1);
        if (q.size() == 0 || q[0].is_done) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("xfer_x", cx, e.x);
          chk("xfer_y", cy, e.y);
          chk("xfer_addr", addr, e.addr);
          chk("xfer_data", data, e.data);
        end
      end
      if (done) begin
        if (q.size() > 0 && q[0].is_done) begin
          void'(q.pop_front());
          chk("done_expected", 1, 1 - int'(busy ? 0 : 1));
        end else begin
          chk("unexpected_done", 1, 0);
        end
      end
      pv  <= v;
      pxf <= v && ready;
      px  <= cx;
      py  <= cy;
      pa  <= addr;
      pd  <= data;
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 3000);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int c;
    int found;
    int hits;
    int drops;
    rst   = 1'b1;
    start = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_v", v, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", cx, 0);
    chk("rst_y", cy, 0);
    chk("rst_v_clk", v, 0);
    rst = 1'b0;

    // Ready always high: exact latency.
    rmode = 1;
    @(posedge clk); #1;
    push_seq();
    start_pulse();
    wait_done(c);
    chk("latency", c, 3 * N + 1);
    @(posedge clk); #1;
    chk("drained_a", q.size(), 0);
    chk("idle_busy", busy, 0);

    // Random ready, several sequences.
    rmode = 0;
    for (int r = 0; r < 4; r++) begin
      push_seq();
      start_pulse();
      wait_done(c);
      @(posedge clk); #1;
      chk("drained_rand", q.size(), 0);
    end

    // Toggling ready.
    rmode = 2;
    push_seq();
    start_pulse();
    wait_done(c);
    @(posedge clk); #1;
    chk("drained_toggle", q.size(), 0);

    // start held high through a whole sequence.
    rmode = 0;
    push_seq();
    start = 1'b1;
    wait_done(c);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("hold_no_restart_busy", busy, 0);
    chk("hold_drained", q.size(), 0);

    // Asynchronous reset during COREID of tile (1,0).
    push_seq();
    start_pulse();
    found = 0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      @(negedge clk);
      if (v && addr == 16'd2 && cx == 1 && cy == 0) found = 1;
    end
    chk("reach_coreid_1_0", found, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_v", v, 0);
    chk("async_busy", busy, 0);
    q.delete();
    @(posedge clk); #1;
    chk("async_x", cx, 0);
    rst = 1'b0;
    push_seq();
    start_pulse();
    wait_done(c);
    @(posedge clk); #1;
    chk("drained_after_rst", q.size(), 0);

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    // Permanent stall must time out after TO cycles.
    rmode = 3;
    @(posedge clk); #1;
    start_pulse();
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("stall_v", v, 1);
      chk("stall_tmo", tmo, 0);
    end
    @(negedge clk);
    chk("to_tmo", tmo, 1);
    chk("to_v", v, 0);
    chk("to_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("to_sticky", tmo, 1);
    @(posedge clk); #1;
    push_seq();
    rmode = 1;
    start_pulse();
    @(negedge clk);
    chk("to_cleared", tmo, 0);
    wait_done(c);
    @(posedge clk); #1;
    chk("drained_after_to", q.size(), 0);
`else
    // Permanent stall waits indefinitely with the first beat held.
    rmode = 3;
    @(posedge clk); #1;
    start_pulse();
    hits  = 0;
    drops = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tmo) hits++;
      if (!v) drops++;
    end
    chk("no_to_tmo", hits, 0);
    chk("no_to_vdrop", drops, 0);
    chk("held_x", cx, 0);
    chk("held_y", cy, 0);
    chk("held_addr", addr, 1);
    chk("held_data", data, 1);
    @(posedge clk); #1;
    push_seq();
    rmode = 1;
    wait_done(c);
    @(posedge clk); #1;
    chk("drained_after_stall", q.size(), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
